// File: rtl/rw_write_arbiter.sv
// rw_write_arbiter: shares the single data-array write port among NUM_PORTS
// write requesters. Round-robin arbitration feeds one registered output stage;
// a tracking FIFO remembers the grant order so that in-order write responses
// are routed back to the requester that issued each write.
// Optional feature macro: RW_WRITE_ARB_GVT_PRIORITY_EN (adds req_gvt_prio,
// priority requesters win over round-robin and may use one extra slot).
module rw_write_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int LOG_OUTSTANDING = 3,
    parameter int ID_W            = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
    input  logic [NUM_PORTS-1:0]        req_gvt_prio,
`endif
    input  logic [NUM_PORTS-1:0]        req_wvalid,
    output logic [NUM_PORTS-1:0]        req_wready,
    input  logic [NUM_PORTS*32-1:0]     req_waddr,
    input  logic [NUM_PORTS*512-1:0]    req_wdata,
    input  logic [NUM_PORTS*64-1:0]     req_wstrb,
    input  logic [NUM_PORTS*ID_W-1:0]   req_wid,
    output logic [NUM_PORTS-1:0]        req_bvalid,
    input  logic [NUM_PORTS-1:0]        req_bready,
    output logic [ID_W-1:0]             req_bid,
    output logic                        wvalid,
    input  logic                        wready,
    output logic [31:0]                 waddr,
    output logic [511:0]                wdata,
    output logic [63:0]                 wstrb,
    output logic [ID_W-1:0]             wid,
    input  logic                        bvalid,
    output logic                        bready,
    input  logic [ID_W-1:0]             bid,
    output logic [LOG_OUTSTANDING:0]    outstanding,
    output logic                        err_unexpected_b
);

    typedef logic [ID_W-1:0] id_t;

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LIMIT = 2 ** LOG_OUTSTANDING;
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
    localparam int DEPTH = LIMIT + 1;
`else
    localparam int DEPTH = LIMIT;
`endif
    localparam int FPTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LOG_OUTSTANDING:0] LIMIT_CNT = (LOG_OUTSTANDING + 1)'(LIMIT);

    // Output stage toward memory
    logic                     r_wvalid;
    logic [31:0]              r_waddr;
    logic [511:0]             r_wdata;
    logic [63:0]              r_wstrb;
    id_t                      r_wid;

    // Arbitration and tracking state
    logic [PTR_W-1:0]         r_ptr;
    logic [PTR_W-1:0]         r_fifo [DEPTH];
    logic [FPTR_W-1:0]        r_wrPtr;
    logic [FPTR_W-1:0]        r_rdPtr;
    logic [LOG_OUTSTANDING:0] r_outstanding;
    logic                     r_errUnexpB;

    // Per-port views of the packed request buses
    logic [31:0]              w_addrArr [NUM_PORTS];
    logic [511:0]             w_dataArr [NUM_PORTS];
    logic [63:0]              w_strbArr [NUM_PORTS];
    id_t                      w_idArr   [NUM_PORTS];

    logic                     w_canIssue;
    logic [PTR_W:0]           w_rrPick;
    logic                     w_grant;
    logic                     w_prioGrant;
    logic [PTR_W-1:0]         w_grantIdx;
    logic                     w_empty;
    logic [PTR_W-1:0]         w_head;
    logic                     w_pop;

    // First set bit of mask searching upward from ptr+1 (wrapping); MSB = found
    function automatic logic [PTR_W:0] rrPick(input logic [NUM_PORTS-1:0] mask,
                                              input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   result;
        logic [PTR_W-1:0] sel;
        int               idx;
        result = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            sel = PTR_W'(idx);
            if (mask[sel]) result = {1'b1, sel};
        end
        return result;
    endfunction

    // Tracking FIFO pointer increment with wrap at DEPTH (DEPTH may be odd)
    function automatic logic [FPTR_W-1:0] fifoNext(input logic [FPTR_W-1:0] p);
        return (p == FPTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unpack the per-requester fields into arrays indexed by port
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_addrArr[p] = req_waddr[32*p +: 32];
            w_dataArr[p] = req_wdata[512*p +: 512];
            w_strbArr[p] = req_wstrb[64*p +: 64];
            w_idArr[p]   = req_wid[ID_W*p +: ID_W];
        end
    end

    assign w_canIssue = (!r_wvalid || wready) && (r_outstanding < LIMIT_CNT);
    assign w_rrPick   = rrPick(req_wvalid, r_ptr);

`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
    logic           w_prioRoom;
    logic [PTR_W:0] w_prioPick;

    assign w_prioRoom = (!r_wvalid || wready) && (r_outstanding <= LIMIT_CNT);
    assign w_prioPick = rrPick(req_wvalid & req_gvt_prio, r_ptr);

    // Priority requesters first (allowed one slot beyond the limit), else round-robin
    always_comb begin
        w_grant     = 1'b0;
        w_prioGrant = 1'b0;
        w_grantIdx  = '0;
        if (w_prioRoom && w_prioPick[PTR_W]) begin
            w_grant     = 1'b1;
            w_prioGrant = 1'b1;
            w_grantIdx  = w_prioPick[PTR_W-1:0];
        end else if (w_canIssue && w_rrPick[PTR_W]) begin
            w_grant    = 1'b1;
            w_grantIdx = w_rrPick[PTR_W-1:0];
        end
    end
`else
    // Plain round-robin grant whenever the output stage and FIFO have room
    always_comb begin
        w_grant     = 1'b0;
        w_prioGrant = 1'b0;
        w_grantIdx  = '0;
        if (w_canIssue && w_rrPick[PTR_W]) begin
            w_grant    = 1'b1;
            w_grantIdx = w_rrPick[PTR_W-1:0];
        end
    end
`endif

    // One-hot accept toward the granted requester only
    always_comb begin
        req_wready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_wready[p] = w_grant && (w_grantIdx == PTR_W'(p));
        end
    end

    assign w_empty = (r_outstanding == '0);
    assign w_head  = r_fifo[r_rdPtr];
    assign bready  = !w_empty && req_bready[w_head];
    assign w_pop   = bvalid && bready;
    assign req_bid = bid;

    // Route the memory response valid to the requester at the FIFO head
    always_comb begin
        req_bvalid = '0;
        if (bvalid && !w_empty) req_bvalid[w_head] = 1'b1;
    end

    // Output valid: set on grant, cleared once accepted with nothing new behind it
    always_ff @(posedge clk) begin
        if (!rstn)        r_wvalid <= 1'b0;
        else if (w_grant) r_wvalid <= 1'b1;
        else if (wready)  r_wvalid <= 1'b0;
    end

    // Output payload loads only on grant so it holds steady while stalled
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_waddr <= w_addrArr[w_grantIdx];
            r_wdata <= w_dataArr[w_grantIdx];
            r_wstrb <= w_strbArr[w_grantIdx];
            r_wid   <= w_idArr[w_grantIdx];
        end
    end

    // Round-robin pointer follows ordinary grants; priority grants leave it alone
    always_ff @(posedge clk) begin
        if (!rstn)                         r_ptr <= PTR_W'(NUM_PORTS - 1);
        else if (w_grant && !w_prioGrant)  r_ptr <= w_grantIdx;
    end

    // Tracking FIFO storage: remembers which port each issued write came from
    always_ff @(posedge clk) begin
        if (w_grant) r_fifo[r_wrPtr] <= w_grantIdx;
    end

    // Tracking FIFO pointers advance on grant (push) and response handshake (pop)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_grant) r_wrPtr <= fifoNext(r_wrPtr);
            if (w_pop)   r_rdPtr <= fifoNext(r_rdPtr);
        end
    end

    // Writes in flight; doubles as the FIFO occupancy count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk) begin
        if (!rstn)                   r_errUnexpB <= 1'b0;
        else if (bvalid && w_empty)  r_errUnexpB <= 1'b1;
    end

    assign wvalid           = r_wvalid;
    assign waddr            = r_waddr;
    assign wdata            = r_wdata;
    assign wstrb            = r_wstrb;
    assign wid              = r_wid;
    assign outstanding      = r_outstanding;
    assign err_unexpected_b = r_errUnexpB;

endmodule

// File: tb/tb_rw_write_arbiter.sv
// Testbench for rw_write_arbiter: directed stimulus, scoreboard queues filled
// by the stimulus process and drained by independent write/response monitors.
module tb_rw_write_arbiter;

    localparam int NP   = 2;
    localparam int LOGO = 3;
    localparam int IDW  = 8;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic [7:0]   id;
    } wExp_t;

    typedef struct {
        logic [1:0] vec;
        logic [7:0] bid;
    } bExp_t;

    logic                 clk;
    logic                 rstn;
    logic [NP-1:0]        req_wvalid;
    logic [NP-1:0]        req_wready;
    logic [NP*32-1:0]     req_waddr;
    logic [NP*512-1:0]    req_wdata;
    logic [NP*64-1:0]     req_wstrb;
    logic [NP*IDW-1:0]    req_wid;
    logic [NP-1:0]        req_bvalid;
    logic [NP-1:0]        req_bready;
    logic [IDW-1:0]       req_bid;
    logic                 wvalid;
    logic                 wready;
    logic [31:0]          waddr;
    logic [511:0]         wdata;
    logic [63:0]          wstrb;
    logic [IDW-1:0]       wid;
    logic                 bvalid;
    logic                 bready;
    logic [IDW-1:0]       bid;
    logic [LOGO:0]        outstanding;
    logic                 err_unexpected_b;
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
    logic [NP-1:0]        req_gvt_prio;
`endif

    int    total = 0;
    int    bad   = 0;
    wExp_t expW[$];
    bExp_t expB[$];
    wExp_t monW;
    bExp_t monB;

    rw_write_arbiter #(
        .NUM_PORTS(NP), .LOG_OUTSTANDING(LOGO), .ID_W(IDW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
        .req_gvt_prio(req_gvt_prio),
`endif
        .req_wvalid(req_wvalid),
        .req_wready(req_wready),
        .req_waddr(req_waddr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .req_wid(req_wid),
        .req_bvalid(req_bvalid),
        .req_bready(req_bready),
        .req_bid(req_bid),
        .wvalid(wvalid),
        .wready(wready),
        .waddr(waddr),
        .wdata(wdata),
        .wstrb(wstrb),
        .wid(wid),
        .bvalid(bvalid),
        .bready(bready),
        .bid(bid),
        .outstanding(outstanding),
        .err_unexpected_b(err_unexpected_b)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [511:0] portData(input int p);
        return {16{32'hD000_0000 + 32'(p)}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] a, input logic [511:0] d,
                                 input logic [63:0] s, input logic [7:0] id);
        req_waddr[32*p +: 32]   = a;
        req_wdata[512*p +: 512] = d;
        req_wstrb[64*p +: 64]   = s;
        req_wid[IDW*p +: IDW]   = id;
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [511:0] d,
                               input logic [63:0] s, input logic [7:0] id);
        wExp_t e;
        e.addr = a; e.data = d; e.strb = s; e.id = id;
        expW.push_back(e);
    endtask

    task automatic expectResp(input logic [1:0] v, input logic [7:0] b);
        bExp_t e;
        e.vec = v; e.bid = b;
        expB.push_back(e);
    endtask

    task automatic doReset;
        checkOutput("write queue drained", 512'(expW.size()), 512'd0);
        checkOutput("resp queue drained", 512'(expB.size()), 512'd0);
        expW.delete();
        expB.delete();
        rstn       = 1'b0;
        req_wvalid = '0;
        req_bready = '0;
        bvalid     = 1'b0;
        wready     = 1'b0;
        bid        = '0;
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
        req_gvt_prio = '0;
`endif
        repeat (2) tick;
        rstn = 1'b1;
    endtask

    // Write monitor: every accepted memory write must match the queue head
    always @(negedge clk) begin
        if (rstn && wvalid && wready) begin
            total++;
            if (expW.size() == 0) begin
                bad++;
                $display("[TB] FAIL write-unexpected: got addr=%h id=%h, expected no write", waddr, wid);
            end else begin
                monW = expW.pop_front();
                if (waddr !== monW.addr || wdata !== monW.data || wstrb !== monW.strb || wid !== monW.id) begin
                    bad++;
                    $display("[TB] FAIL write-beat: got addr=%h id=%h strb=%h d0=%h, expected addr=%h id=%h strb=%h d0=%h",
                             waddr, wid, wstrb, wdata[31:0], monW.addr, monW.id, monW.strb, monW.data[31:0]);
                end
            end
        end
    end

    // Response monitor: every accepted response must be routed as expected
    always @(negedge clk) begin
        if (rstn && bvalid && bready) begin
            total++;
            if (expB.size() == 0) begin
                bad++;
                $display("[TB] FAIL resp-unexpected: got req_bvalid=%b bid=%h, expected none", req_bvalid, req_bid);
            end else begin
                monB = expB.pop_front();
                if (req_bvalid !== monB.vec || req_bid !== monB.bid) begin
                    bad++;
                    $display("[TB] FAIL resp-route: got req_bvalid=%b bid=%h, expected req_bvalid=%b bid=%h",
                             req_bvalid, req_bid, monB.vec, monB.bid);
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        rstn = 1'b0; req_wvalid = '0; req_bready = '0; bvalid = 1'b0; wready = 1'b0; bid = '0;
        req_waddr = '0; req_wdata = '0; req_wstrb = '0; req_wid = '0;
`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
        req_gvt_prio = '0;
`endif
        doReset;
        @(negedge clk);
        checkOutput("reset wvalid", wvalid, 0);
        checkOutput("reset outstanding", outstanding, 0);
        checkOutput("reset err", err_unexpected_b, 0);
        checkOutput("reset req_wready", req_wready, 0);
        checkOutput("reset bready", bready, 0);
        tick;

        // Alternating round-robin with both ports requesting
        applyStimulus(0, 32'h1000, portData(0), '1, 8'h03);
        applyStimulus(1, 32'h1010, portData(1), '1, 8'h04);
        req_wvalid = 2'b11;
        wready     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expectWrite(32'h1000, portData(0), '1, 8'h03);
            else            expectWrite(32'h1010, portData(1), '1, 8'h04);
            @(negedge clk);
            checkOutput("rr grant", req_wready, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("wvalid latency", wvalid, (k > 0) ? 1 : 0);
            tick;
        end
        req_wvalid = '0;
        @(negedge clk);
        checkOutput("last write on bus", wvalid, 1);
        tick;
        @(negedge clk);
        checkOutput("idle after burst", wvalid, 0);
        checkOutput("outstanding after burst", outstanding, 4);
        tick;
        doReset;
        @(negedge clk);
        checkOutput("reset drops outstanding", outstanding, 0);
        checkOutput("reset drops wvalid", wvalid, 0);
        tick;

        // Stall: payload held stable while wready is low
        applyStimulus(1, 32'h40, {16{32'h1234_5678}}, '1, 8'h07);
        req_wvalid = 2'b10;
        wready     = 1'b0;
        expectWrite(32'h40, {16{32'h1234_5678}}, '1, 8'h07);
        @(negedge clk);
        checkOutput("stall first grant", req_wready, 2'b10);
        checkOutput("stall wvalid before", wvalid, 0);
        tick;
        applyStimulus(1, 32'h80, {16{32'h9ABC_DEF0}}, 64'h0F0F, 8'h09);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall wvalid", wvalid, 1);
            checkOutput("stall waddr", waddr, 32'h40);
            checkOutput("stall wdata", wdata, {16{32'h1234_5678}});
            checkOutput("stall wstrb", wstrb, {64{1'b1}});
            checkOutput("stall no grant", req_wready, 2'b00);
            tick;
        end
        wready = 1'b1;
        expectWrite(32'h80, {16{32'h9ABC_DEF0}}, 64'h0F0F, 8'h09);
        @(negedge clk);
        checkOutput("stall release grant", req_wready, 2'b10);
        checkOutput("stall release waddr", waddr, 32'h40);
        tick;
        req_wvalid = '0;
        tick;
        @(negedge clk);
        checkOutput("stall drained", wvalid, 0);
        tick;
        doReset;

        // Outstanding limit and same-cycle pop not freeing a slot
        req_wvalid = 2'b01;
        wready     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 32'h100 + 32'(4 * k), portData(0), '1, 8'h03);
            expectWrite(32'h100 + 32'(4 * k), portData(0), '1, 8'h03);
            @(negedge clk);
            checkOutput("fill outstanding", outstanding, k);
            tick;
        end
        @(negedge clk);
        checkOutput("full no grant", req_wready, 2'b00);
        checkOutput("full outstanding", outstanding, 8);
        tick;
        @(negedge clk);
        checkOutput("full bus idle", wvalid, 0);
        tick;
        bvalid     = 1'b1;
        bid        = 8'h21;
        req_bready = 2'b11;
        expectResp(2'b01, 8'h21);
        @(negedge clk);
        checkOutput("full bready", bready, 1);
        checkOutput("pop same cycle no grant", req_wready, 2'b00);
        tick;
        bvalid = 1'b0;
        applyStimulus(0, 32'h200, portData(0), '1, 8'h03);
        expectWrite(32'h200, portData(0), '1, 8'h03);
        @(negedge clk);
        checkOutput("grant after pop", req_wready, 2'b01);
        checkOutput("outstanding after pop", outstanding, 7);
        tick;
        req_wvalid = '0;
        @(negedge clk);
        checkOutput("refilled outstanding", outstanding, 8);
        tick;
        doReset;

        // Response routing in issue order, with head blocked by bready
        applyStimulus(0, 32'h1000, portData(0), '1, 8'h03);
        applyStimulus(1, 32'h1010, portData(1), '1, 8'h04);
        wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_wvalid = (k == 1) ? 2'b10 : 2'b01;
            if (k == 1) expectWrite(32'h1010, portData(1), '1, 8'h04);
            else        expectWrite(32'h1000, portData(0), '1, 8'h03);
            tick;
        end
        req_wvalid = '0;
        @(negedge clk);
        checkOutput("three in flight", outstanding, 3);
        tick;
        bvalid = 1'b1; bid = 8'h05; req_bready = 2'b11;
        expectResp(2'b01, 8'h05);
        tick;
        bid = 8'h06; req_bready = 2'b01;
        @(negedge clk);
        checkOutput("head blocked bready", bready, 0);
        checkOutput("head blocked route", req_bvalid, 2'b10);
        checkOutput("head blocked bid", req_bid, 8'h06);
        checkOutput("head blocked outstanding", outstanding, 2);
        tick;
        req_bready = 2'b11;
        expectResp(2'b10, 8'h06);
        tick;
        bid = 8'h07;
        expectResp(2'b01, 8'h07);
        tick;
        bvalid = 1'b0;
        @(negedge clk);
        checkOutput("all acknowledged", outstanding, 0);
        checkOutput("no error", err_unexpected_b, 0);
        tick;
        doReset;

        // Unexpected response with nothing outstanding
        bvalid = 1'b1; bid = 8'h09; req_bready = 2'b11;
        @(negedge clk);
        checkOutput("unexpected bready", bready, 0);
        checkOutput("unexpected route", req_bvalid, 2'b00);
        checkOutput("err before edge", err_unexpected_b, 0);
        tick;
        bvalid = 1'b0;
        @(negedge clk);
        checkOutput("err set", err_unexpected_b, 1);
        tick;
        @(negedge clk);
        checkOutput("err sticky", err_unexpected_b, 1);
        tick;
        doReset;
        @(negedge clk);
        checkOutput("err cleared by reset", err_unexpected_b, 0);
        tick;

`ifdef RW_WRITE_ARB_GVT_PRIORITY_EN
        // Priority grant keeps the pointer and may use one extra slot
        applyStimulus(0, 32'h1000, portData(0), '1, 8'h03);
        applyStimulus(1, 32'h1010, portData(1), '1, 8'h04);
        wready = 1'b1;
        req_wvalid = 2'b01;
        expectWrite(32'h1000, portData(0), '1, 8'h03);
        tick;
        req_wvalid = 2'b11; req_gvt_prio = 2'b01;
        expectWrite(32'h1000, portData(0), '1, 8'h03);
        @(negedge clk);
        checkOutput("prio beats rr", req_wready, 2'b01);
        tick;
        req_gvt_prio = 2'b00;
        expectWrite(32'h1010, portData(1), '1, 8'h04);
        @(negedge clk);
        checkOutput("pointer kept after prio", req_wready, 2'b10);
        tick;
        req_wvalid = '0;
        repeat (2) tick;
        req_wvalid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            expectWrite(32'h1000, portData(0), '1, 8'h03);
            tick;
        end
        @(negedge clk);
        checkOutput("prio full no rr grant", req_wready, 2'b00);
        checkOutput("prio full outstanding", outstanding, 8);
        tick;
        req_gvt_prio = 2'b01;
        expectWrite(32'h1000, portData(0), '1, 8'h03);
        @(negedge clk);
        checkOutput("prio bypass grant", req_wready, 2'b01);
        tick;
        @(negedge clk);
        checkOutput("prio extra outstanding", outstanding, 9);
        checkOutput("prio cap", req_wready, 2'b00);
        tick;
        req_wvalid = '0; req_gvt_prio = '0;
        repeat (2) tick;
        doReset;
`endif

        doReset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
